// File: rtl/pe_partial_sum_accumulator.sv
// Partial-sum accumulator behind the 16-lane PE: sums signed beats per group, emits one saturated result.
// Optional build macro PE_ACC_RELU_EN: negative results are output as zero after the OUT_W clamp.
module pe_partial_sum_accumulator #(
    parameter int unsigned IN_W      = 16,
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned MAX_BEATS = 64,
    parameter int unsigned CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_sat
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] beat_cnt_q;
    logic             grp_sat_q;

    logic             accept;
    logic             group_end;
    logic             acc_ovf;
    logic             out_ovf;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] beat_next;
    logic [OUT_W-1:0] res_clamped;
    logic [OUT_W-1:0] res_final;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};
        acc_ovf  = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        if (acc_ovf) begin
            acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next = sum_wide[ACC_W-1:0];
        end
        // Fits in OUT_W iff every bit from the OUT_W sign bit upward matches the acc sign.
        out_ovf = acc_next[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){acc_next[ACC_W-1]}};
        if (out_ovf) begin
            res_clamped = acc_next[ACC_W-1] ? OUT_MIN : OUT_MAX;
        end else begin
            res_clamped = acc_next[OUT_W-1:0];
        end
`ifdef PE_ACC_RELU_EN
        res_final = res_clamped[OUT_W-1] ? '0 : res_clamped;
`else
        res_final = res_clamped;
`endif
        beat_next = beat_cnt_q + CNT_W'(1);
        group_end = in_last || (beat_next == CNT_W'(MAX_BEATS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            beat_cnt_q <= '0;
            grp_sat_q  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_beats  <= '0;
            out_sat    <= 1'b0;
        end else begin
            if (accept) begin
                if (group_end) begin
                    acc_q      <= '0;
                    beat_cnt_q <= '0;
                    grp_sat_q  <= 1'b0;
                end else begin
                    acc_q      <= acc_next;
                    beat_cnt_q <= beat_next;
                    grp_sat_q  <= grp_sat_q | acc_ovf;
                end
            end
            // A new result may overwrite the slot in the same cycle the old one is taken.
            if (accept && group_end) begin
                out_valid <= 1'b1;
                out_data  <= res_final;
                out_beats <= beat_next;
                out_sat   <= grp_sat_q | acc_ovf | out_ovf;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
